vetris_row_scanout: RTL

Row framebuffer and pixel scan-out stage directly downstream of the CPU core. It captures 32-bit row images written by the CPU's writeback stage (row index plus row data) into a row array. On each display frame tick it streams the array out one pixel per beat over a valid/ready handshake to the display driver. Optional double buffering keeps a frame tear-free while the CPU redraws the playfield.

---
 rtl/vetris_row_scanout.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vetris_row_scanout.sv
// Row framebuffer with valid/ready pixel scan-out; one beat per pixel, row-major.
// Define VETRIS_DBUF_EN for a separate display array that is refreshed on commit.
module vetris_row_scanout #(
    parameter int ROWS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        row_wr_en,
    input  logic [4:0]  row_index,
    input  logic [31:0] row_data,
    input  logic        clear_all,
    input  logic        commit,
    input  logic        scan_start,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [4:0]  pix_x,
    output logic [4:0]  pix_y,
    output logic        pix_on,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [0:0] {IDLE, SCAN} state_t;

    localparam logic [5:0] ROWS_L = 6'(ROWS);
    localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

    state_t      state_q;
    logic        pix_valid_q, pix_on_q, frame_done_q, busy_q;
    logic [4:0]  pix_x_q, pix_y_q;
    logic [31:0] back_q [32];

    logic        accept, last_beat;
    logic [4:0]  x_d, y_d, rd_x, rd_y;
    logic        rd_bit;

    always_comb begin
        accept    = (state_q == SCAN) && pix_ready;
        last_beat = (pix_x_q == 5'd31) && (pix_y_q == LAST_Y);
        x_d       = pix_x_q + 5'd1;
        y_d       = (pix_x_q == 5'd31) ? pix_y_q + 5'd1 : pix_y_q;
        rd_x      = (state_q == IDLE) ? 5'd0 : x_d;
        rd_y      = (state_q == IDLE) ? 5'd0 : y_d;
    end

    // Rows at or beyond ROWS are never written, so they stay zero and are never read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) back_q[i] <= '0;
        end else if (clear_all) begin
            for (int i = 0; i < 32; i++) back_q[i] <= '0;
        end else if (row_wr_en && ({1'b0, row_index} < ROWS_L)) begin
            back_q[row_index] <= row_data;
        end
    end

`ifdef VETRIS_DBUF_EN
    logic [31:0] front_q [32];
    logic        pend_q;
    logic        copy_d;

    // A commit seen during a frame is deferred to the edge that ends the frame.
    assign copy_d = ((state_q == IDLE) && commit) ||
                    (accept && last_beat && (pend_q || commit));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) front_q[i] <= '0;
        end else if (copy_d) begin
            front_q <= back_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
        end else if (accept && last_beat) begin
            pend_q <= 1'b0;
        end else if ((state_q == SCAN) && commit) begin
            pend_q <= 1'b1;
        end
    end

    assign rd_bit = front_q[rd_y][rd_x];
`else
    logic unused_commit;
    assign unused_commit = commit;
    assign rd_bit        = back_q[rd_y][rd_x];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_on_q     <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (scan_start) begin
                        state_q     <= SCAN;
                        pix_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        pix_x_q     <= '0;
                        pix_y_q     <= '0;
                        pix_on_q    <= rd_bit;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        if (last_beat) begin
                            state_q      <= IDLE;
                            pix_valid_q  <= 1'b0;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            pix_x_q      <= '0;
                            pix_y_q      <= '0;
                            pix_on_q     <= 1'b0;
                        end else begin
                            pix_x_q  <= x_d;
                            pix_y_q  <= y_d;
                            pix_on_q <= rd_bit;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_on     = pix_on_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
